bus_xfer_ctrl: RTL and testbench

// - Downstream companion of the bus arbiter. It consumes the one-hot grant vector,

---
 rtl/bus_pkg.sv | 22 ++
 rtl/grant_encoder.sv | 22 ++
 rtl/bus_xfer_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_bus_xfer_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus types for the arbiter / transfer controller pair.
// Grant vector, idle constants and the transfer FSM encoding.
package bus_pkg;

  localparam int N_MASTERS = 3;

  typedef logic [N_MASTERS-1:0] arb_vector;

  localparam arb_vector NO_GRANT   = '0;
  localparam arb_vector NO_REQUEST = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2
  } xfer_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/grant_encoder.sv
// One-hot grant to master index, with a flag that the
// vector really is one-hot and a flag that any bit is set.
module grant_encoder #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             onehot_ok,
  output logic             any_set
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) idx = IDX_W'(i);
    end
    onehot_ok = $onehot(grant);
    any_set   = |grant;
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Grant-driven burst controller: latches the granted master's
// command, runs the beats on the slave port, acks the arbiter.
module bus_xfer_ctrl #(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_MASTERS-1:0]      bus_grant,
  input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [N_MASTERS-1:0]      m_we,
  input  logic [N_MASTERS*LEN_W-1:0] m_len,
  output logic [N_MASTERS-1:0]      m_beat,
  output logic [N_MASTERS-1:0]      m_done,
  output logic [DATA_W-1:0]         m_rdata,
  output logic                      bus_ack,
  output logic                      xfer_err,
  output logic                      grant_err,
  output logic                      s_valid,
  output logic [ADDR_W-1:0]         s_addr,
  output logic [DATA_W-1:0]         s_wdata,
  output logic                      s_we,
  input  logic                      s_ready,
  input  logic [DATA_W-1:0]         s_rdata
);
  import bus_pkg::*;

  localparam int IDX_W = idx_width(N_MASTERS);
  localparam logic [ADDR_W-1:0] STRIDE =
    ADDR_W'(DATA_W / 8);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  xfer_state_t state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 we_q, we_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           wait_q, wait_d;
  logic                 bus_ack_q, bus_ack_d;
  logic                 xfer_err_q, xfer_err_d;
  logic                 grant_err_q, grant_err_d;
  logic [N_MASTERS-1:0] m_done_q, m_done_d;

  logic [IDX_W-1:0]  g_idx;
  logic              g_ok;
  logic              g_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic              sel_we;
  logic [DATA_W-1:0] cur_wdata;
  logic              in_xfer;
  logic              beat;

  grant_encoder #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_genc (
    .grant     (bus_grant),
    .idx       (g_idx),
    .onehot_ok (g_ok),
    .any_set   (g_any)
  );

  // Command fields of the master being granted now, and the
  // live write data of the master that owns the transfer.
  always_comb begin
    sel_addr  = '0;
    sel_len   = '0;
    sel_we    = 1'b0;
    cur_wdata = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (g_idx == IDX_W'(i)) begin
        sel_addr = m_addr[i*ADDR_W +: ADDR_W];
        sel_len  = m_len[i*LEN_W +: LEN_W];
        sel_we   = m_we[i];
      end
      if (idx_q == IDX_W'(i)) begin
        cur_wdata = m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign in_xfer = (state_q == XFER);
  assign beat    = in_xfer & s_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    len_d       = len_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    bus_ack_d   = 1'b0;
    xfer_err_d  = 1'b0;
    grant_err_d = 1'b0;
    m_done_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (g_ok) begin
          idx_d   = g_idx;
          addr_d  = sel_addr;
          len_d   = sel_len;
          we_d    = sel_we;
          cnt_d   = '0;
          wait_d  = '0;
          state_d = XFER;
        end else if (g_any) begin
          grant_err_d = 1'b1;
        end
      end
      XFER: begin
        if (s_ready) begin
          addr_d = addr_q + STRIDE;
          cnt_d  = cnt_q + 1'b1;
          wait_d = '0;
          if (cnt_q == len_q) begin
            state_d   = ACK;
            bus_ack_d = 1'b1;
            m_done_d  = N_MASTERS'(1) << idx_q;
          end
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_q == WAIT_LAST) begin
            state_d    = ACK;
            bus_ack_d  = 1'b1;
            xfer_err_d = 1'b1;
            m_done_d   = N_MASTERS'(1) << idx_q;
          end
        end
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      wait_q      <= '0;
      bus_ack_q   <= 1'b0;
      xfer_err_q  <= 1'b0;
      grant_err_q <= 1'b0;
      m_done_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      bus_ack_q   <= bus_ack_d;
      xfer_err_q  <= xfer_err_d;
      grant_err_q <= grant_err_d;
      m_done_q    <= m_done_d;
    end
  end

  assign s_valid   = in_xfer;
  assign s_addr    = in_xfer ? addr_q : '0;
  assign s_we      = in_xfer & we_q;
  assign s_wdata   = in_xfer ? cur_wdata : '0;
  assign m_beat    = beat ? (N_MASTERS'(1) << idx_q) : '0;
  assign m_rdata   = beat ? s_rdata : '0;
  assign bus_ack   = bus_ack_q;
  assign m_done    = m_done_q;
  assign xfer_err  = xfer_err_q;
  assign grant_err = grant_err_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed and random checks of bus_xfer_ctrl against a
// transaction-level model of the grant/burst/ack protocol.
module tb_bus_xfer_ctrl;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0]    bus_grant = '0;
  logic [N*AW-1:0] m_addr = '0;
  logic [N*DW-1:0] m_wdata = '0;
  logic [N-1:0]    m_we = '0;
  logic [N*LW-1:0] m_len = '0;
  logic            s_ready = 1'b0;
  logic [DW-1:0]   s_rdata = '0;
  logic [N-1:0]    m_beat, m_done;
  logic [DW-1:0]   m_rdata, s_wdata;
  logic            bus_ack, xfer_err, grant_err;
  logic            s_valid, s_we;
  logic [AW-1:0]   s_addr;

  int checks = 0;
  int errors = 0;

  bus_xfer_ctrl #(
    .N_MASTERS (N), .ADDR_W (AW), .DATA_W (DW),
    .LEN_W (LW), .TIMEOUT (TO)
  ) dut (
    .clk (clk), .reset_n (reset_n),
    .bus_grant (bus_grant), .m_addr (m_addr),
    .m_wdata (m_wdata), .m_we (m_we), .m_len (m_len),
    .m_beat (m_beat), .m_done (m_done),
    .m_rdata (m_rdata), .bus_ack (bus_ack),
    .xfer_err (xfer_err), .grant_err (grant_err),
    .s_valid (s_valid), .s_addr (s_addr),
    .s_wdata (s_wdata), .s_we (s_we),
    .s_ready (s_ready), .s_rdata (s_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Transaction model: 0 = idle, 1 = moving beats, 2 = ack
  int ph = 0;
  int midx = 0;
  int mbeats = 0;
  int mlen = 0;
  int mwait = 0;
  logic [AW-1:0] mstart = '0;
  logic mwe = 1'b0;
  logic mabort = 1'b0;
  logic mgerr = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph = 0;
      mgerr = 1'b0;
      mabort = 1'b0;
    end else begin
      mgerr = 1'b0;
      if (ph == 0) begin
        if ($countones(bus_grant) == 1) begin
          for (int i = 0; i < N; i++)
            if (bus_grant[i]) midx = i;
          mstart = m_addr[midx*AW +: AW];
          mlen   = int'(m_len[midx*LW +: LW]);
          mwe    = m_we[midx];
          mbeats = 0;
          mwait  = 0;
          ph = 1;
        end else if ($countones(bus_grant) > 1) begin
          mgerr = 1'b1;
        end
      end else if (ph == 1) begin
        if (s_ready) begin
          mbeats++;
          mwait = 0;
          if (mbeats == mlen + 1) begin
            ph = 2;
            mabort = 1'b0;
          end
        end else begin
          mwait++;
          if (mwait == TO) begin
            ph = 2;
            mabort = 1'b1;
          end
        end
      end else begin
        ph = 0;
      end
    end
  end

  logic [N-1:0]  e_beat, e_done;
  logic [AW-1:0] e_addr;
  logic          e_busy;

  always @(negedge clk) begin
    e_busy = (ph == 1);
    e_addr = e_busy ? AW'(int'(mstart) + mbeats * (DW / 8))
                    : '0;
    e_beat = (e_busy && s_ready) ? N'(1) << midx : '0;
    e_done = (ph == 2) ? N'(1) << midx : '0;
    chk("s_valid", s_valid, e_busy);
    chk("s_addr", s_addr, e_addr);
    chk("s_we", s_we, e_busy && mwe);
    chk("s_wdata", s_wdata,
        e_busy ? m_wdata[midx*DW +: DW] : '0);
    chk("m_beat", m_beat, e_beat);
    chk("m_rdata", m_rdata, (|e_beat) ? s_rdata : '0);
    chk("bus_ack", bus_ack, ph == 2);
    chk("m_done", m_done, e_done);
    chk("xfer_err", xfer_err, (ph == 2) && mabort);
    chk("grant_err", grant_err, mgerr);
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic setm(input int i,
                      input logic [AW-1:0] a,
                      input logic [LW-1:0] l,
                      input logic we,
                      input logic [DW-1:0] wd);
    m_addr[i*AW +: AW]  = a;
    m_len[i*LW +: LW]   = l;
    m_we[i]             = we;
    m_wdata[i*DW +: DW] = wd;
  endtask

  logic [N-1:0] multi [4];
  int thr;

  initial begin
    multi[0] = 3'b011; multi[1] = 3'b101;
    multi[2] = 3'b110; multi[3] = 3'b111;
    repeat (3) nxt();
    chk("rst_valid", s_valid, 0);
    chk("rst_ack", bus_ack, 0);
    chk("rst_done", m_done, 0);
    reset_n = 1'b1;
    nxt();

    // 4-beat write burst from master 1
    setm(1, 16'h0100, 4'd3, 1'b1, 32'h1111_2222);
    s_ready = 1'b1;
    bus_grant = 3'b010;
    nxt();
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("t1_addr", s_addr, 64'h0100 + 4 * k);
      chk("t1_beat", m_beat, 3'b010);
      chk("t1_wdata", s_wdata, 32'h1111_2222);
      nxt();
    end
    bus_grant = '0;
    smp();
    chk("t1_ack", bus_ack, 1);
    chk("t1_done", m_done, 3'b010);
    chk("t1_valid", s_valid, 0);
    nxt();
    smp();
    chk("t1_ack_off", bus_ack, 0);

    // single-beat read, slave stalls 3 cycles
    setm(0, 16'h0040, 4'd0, 1'b0, 32'h0);
    s_ready = 1'b0;
    s_rdata = 32'hDEAD_BEEF;
    bus_grant = 3'b001;
    nxt();
    repeat (3) begin
      smp();
      chk("t2_stall", m_beat, 0);
      nxt();
    end
    s_ready = 1'b1;
    smp();
    chk("t2_beat", m_beat, 3'b001);
    chk("t2_rdata", m_rdata, 32'hDEAD_BEEF);
    nxt();
    bus_grant = '0;
    s_ready = 1'b0;
    smp();
    chk("t2_ack", bus_ack, 1);
    chk("t2_err", xfer_err, 0);
    nxt();

    // timeout abort on master 2
    setm(2, 16'h2000, 4'd2, 1'b0, 32'h0);
    bus_grant = 3'b100;
    nxt();
    repeat (TO) begin
      smp();
      chk("t3_wait", s_valid, 1);
      nxt();
    end
    bus_grant = '0;
    smp();
    chk("t3_valid", s_valid, 0);
    chk("t3_ack", bus_ack, 1);
    chk("t3_err", xfer_err, 1);
    chk("t3_done", m_done, 3'b100);
    nxt();
    smp();
    chk("t3_err_off", xfer_err, 0);

    // multi-hot grant
    bus_grant = 3'b011;
    nxt();
    smp();
    chk("t4_gerr", grant_err, 1);
    chk("t4_valid", s_valid, 0);
    bus_grant = '0;
    nxt();
    smp();
    chk("t4_gerr_off", grant_err, 0);
    chk("t4_ack", bus_ack, 0);

    // address wrap
    setm(0, 16'hFFFC, 4'd1, 1'b1, 32'h5A5A_0000);
    s_ready = 1'b1;
    bus_grant = 3'b001;
    nxt();
    smp();
    chk("t5_addr0", s_addr, 16'hFFFC);
    nxt();
    smp();
    chk("t5_addr1", s_addr, 16'h0000);
    nxt();
    bus_grant = '0;
    nxt();

    // reset in the middle of a burst
    setm(1, 16'h0200, 4'd3, 1'b0, 32'h0);
    bus_grant = 3'b010;
    nxt();
    nxt();
    smp();
    chk("t6_addr", s_addr, 16'h0204);
    reset_n = 1'b0;
    #1;
    chk("t6_rvalid", s_valid, 0);
    chk("t6_rbeat", m_beat, 0);
    chk("t6_raddr", s_addr, 0);
    bus_grant = '0;
    nxt();
    reset_n = 1'b1;
    repeat (4) begin
      smp();
      chk("t6_noack", bus_ack, 0);
      nxt();
    end
    bus_grant = 3'b010;
    nxt();
    smp();
    chk("t6_restart", s_addr, 16'h0200);
    chk("t6_beat", m_beat, 3'b010);
    repeat (4) nxt();
    bus_grant = '0;
    nxt();

    // random traffic
    thr = 80;
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) begin
        case ($urandom_range(0, 3))
          0: thr = 0;
          1: thr = 30;
          2: thr = 80;
          default: thr = 100;
        endcase
      end
      m_addr  = {$urandom, $urandom};
      m_wdata = {$urandom, $urandom, $urandom};
      m_we    = N'($urandom);
      m_len   = {N*LW{1'b0}} | N*LW'($urandom);
      s_rdata = $urandom;
      s_ready = ($urandom_range(0, 99) < thr);
      if (ph == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: bus_grant = '0;
          9: bus_grant = multi[$urandom_range(0, 3)];
          default: bus_grant = N'(1) << $urandom_range(0, N - 1);
        endcase
      end else if ($urandom_range(0, 9) < 3) begin
        bus_grant = N'($urandom);
      end
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        nxt();
        reset_n = 1'b1;
      end
      nxt();
    end

    bus_grant = '0;
    repeat (3) nxt();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
